multicycle_control_fsm: RTL and testbench

Main control sequencer for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the PC write strobe, memory strobes, register-file write and datapath mux selects. It sits beside the PC register and shared memory, and stalls on a memory ready handshake. The single-cycle build does not use it.

---
 rtl/multicycle_control_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core (fetch/decode/exec/mem/wb).
// Optional terminal ILLEGAL state when ILLEGAL_TRAP_EN is defined.
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [3:0] state_out,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int CW =
    (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q;
  logic          is_wait;
  logic          expired;
  logic          pc_update;
  logic          branch;
  logic          taken;
  logic [2:0]    alu_exec;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  assign is_wait = (state == S_FETCH) ||
                   (state == S_MEMREAD) ||
                   (state == S_MEMWRITE);

  // Expiry only counts when the access did not complete this cycle.
  assign expired = (MEM_WAIT_MAX > 0) && is_wait && !mem_ready &&
                   (wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!rst || next_state != state || expired)
      wait_cnt <= '0;
    else if ((MEM_WAIT_MAX > 0) && is_wait && !mem_ready)
      wait_cnt <= wait_cnt + 1'b1;
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst)                        illegal_q <= 1'b0;
    else if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  always_comb begin
    unique case (funct3)
      3'b000: alu_exec = (state == S_EXECR &&
                          opcode == 7'b0110011 &&
                          funct7b5) ? ALU_SUB : ALU_ADD;
      3'b100: alu_exec = ALU_XOR;
      3'b110: alu_exec = ALU_OR;
      3'b111: alu_exec = ALU_AND;
      3'b010: alu_exec = ALU_SLT;
      default: alu_exec = ALU_ADD;
    endcase
  end

  always_comb begin
    unique case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state  = state;
    pc_update   = 1'b0;
    branch      = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    mem_timeout = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          next_state = S_DECODE;
        end else if (expired) begin
          mem_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (opcode)
          7'b0000011,
          7'b0100011: next_state = S_MEMADR;
          7'b0110011: next_state = S_EXECR;
          7'b0010011: next_state = S_EXECI;
          7'b1101111: next_state = S_JAL;
          7'b1100011: next_state = S_BRANCH;
          default:    next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
        else if (expired) begin
          mem_timeout = 1'b1;
          next_state  = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
        else if (expired) begin
          mem_timeout = 1'b1;
          next_state  = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_exec;
        next_state  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_exec;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        next_state  = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = S_ILLEGAL;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase
    pc_write      = pc_update | (branch & taken);
    state_out     = state;
    illegal_instr = illegal_q;
    // Reset silences every output, including the debug state view.
    if (!rst) begin
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_control   = ALU_ADD;
      state_out     = 4'd0;
      mem_timeout   = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level reference model,
// random instruction mix and stalls, plus directed reset/timeout steps.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic       rst_to;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, adr_src, mem_read, mem_write;
  logic       ir_write, reg_write, mem_timeout, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state_out;

  logic       t_pc_write, t_adr_src, t_mem_read, t_mem_write;
  logic       t_ir_write, t_reg_write, t_mem_timeout, t_illegal;
  logic [1:0] t_result_src, t_alu_src_a, t_alu_src_b;
  logic [2:0] t_alu_control;
  logic [3:0] t_state_out;

  int compared;
  int mismatched;
  int seq[$];

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  multicycle_control_fsm #(.MEM_WAIT_MAX(0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .state_out(state_out),
    .mem_timeout(mem_timeout), .illegal_instr(illegal_instr)
  );

  multicycle_control_fsm #(.MEM_WAIT_MAX(2)) dut_to (
    .clk(clk), .rst(rst_to), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(t_pc_write), .adr_src(t_adr_src),
    .mem_read(t_mem_read), .mem_write(t_mem_write),
    .ir_write(t_ir_write), .reg_write(t_reg_write),
    .result_src(t_result_src), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .alu_control(t_alu_control),
    .state_out(t_state_out), .mem_timeout(t_mem_timeout),
    .illegal_instr(t_illegal)
  );

  wire [20:0] obs = {pc_write, adr_src, mem_read, mem_write,
                     ir_write, reg_write, result_src, alu_src_a,
                     alu_src_b, alu_control, state_out,
                     mem_timeout, illegal_instr};
  wire [20:0] obs_to = {t_pc_write, t_adr_src, t_mem_read,
                        t_mem_write, t_ir_write, t_reg_write,
                        t_result_src, t_alu_src_a, t_alu_src_b,
                        t_alu_control, t_state_out,
                        t_mem_timeout, t_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exec_alu(logic [2:0] f3, bit sub_ok);
    case (f3)
      3'd0:    return sub_ok ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs for one cycle spent in step s of an instruction.
  function automatic logic [20:0] exp_vec(int s, bit rdy, bit to,
                                          logic [6:0] opc,
                                          logic [2:0] f3,
                                          bit f7, bit z);
    bit pcw = 0, adr = 0, mr = 0, mw = 0, irw = 0, rw = 0;
    bit tmo = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] alu = 0;
    case (s)
      0: begin
        mr = 1; sb = 2; rs = 2;
        if (rdy) begin irw = 1; pcw = 1; end
        else tmo = to;
      end
      1: begin sa = 1; sb = 1; end
      2: begin sa = 2; sb = 1; end
      3: begin mr = 1; adr = 1; tmo = !rdy && to; end
      4: begin rs = 1; rw = 1; end
      5: begin mw = 1; adr = 1; tmo = !rdy && to; end
      6: begin sa = 2; alu = exec_alu(f3, f7 && opc == 7'b0110011); end
      7: rw = 1;
      8: begin sa = 2; sb = 1; alu = exec_alu(f3, 1'b0); end
      9: begin sa = 1; sb = 2; pcw = 1; end
      10: begin
        sa = 2; alu = 3'd1;
        pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
      end
      11: ill = TRAP;
      default: ;
    endcase
    return {pcw, adr, mr, mw, irw, rw, rs, sa, sb, alu, 4'(s), tmo, ill};
  endfunction

  function automatic void build_seq(logic [6:0] opc);
    case (opc)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 7};
      7'b0010011: seq = '{0, 1, 8, 7};
      7'b1101111: seq = '{0, 1, 9, 7};
      7'b1100011: seq = '{0, 1, 10};
      default:    seq = '{0, 1, 11};
    endcase
  endfunction

  task automatic chk(string tag, logic [20:0] got, logic [20:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic cycle(string tag, int s, bit rdy);
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, obs, exp_vec(s, rdy, 1'b0, opcode, funct3, funct7b5, zero));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b0;
    mem_ready = 1'($urandom);
    @(negedge clk);
    chk("in_reset", obs, 21'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_instr(string tag, logic [6:0] opc, logic [2:0] f3,
                           bit f7, bit z, int max_stall);
    opcode = opc; funct3 = f3; funct7b5 = f7; zero = z;
    build_seq(opc);
    foreach (seq[i]) begin
      if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
        repeat ($urandom_range(0, max_stall)) cycle(tag, seq[i], 1'b0);
        cycle(tag, seq[i], 1'b1);
      end else begin
        cycle(tag, seq[i], 1'($urandom));
      end
    end
`ifdef ILLEGAL_TRAP_EN
    if (seq[seq.size()-1] == 11) begin
      repeat (3) cycle({tag, "_hold"}, 11, 1'($urandom));
      reset_cycle();
    end
`endif
  endtask

  logic [6:0] legal_ops [6];
  logic [6:0] bad_ops [4];

  initial begin
    compared = 0; mismatched = 0;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011,
                  7'b0010011, 7'b1101111, 7'b1100011};
    bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1110011};
    rst = 1'b0; rst_to = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 0;
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("reset", obs, 21'd0);
      chk("reset_to", obs_to, 21'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    run_instr("lw", 7'b0000011, 3'd2, 1'b0, 1'b0, 0);
    run_instr("sw", 7'b0100011, 3'd2, 1'b0, 1'b0, 0);
    run_instr("sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 0);
    run_instr("add", 7'b0110011, 3'd0, 1'b0, 1'b0, 0);
    run_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0);
    run_instr("slt", 7'b0110011, 3'd2, 1'b0, 1'b0, 0);
    run_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 0);
    run_instr("beq_t", 7'b1100011, 3'd0, 1'b0, 1'b1, 0);
    run_instr("beq_nt", 7'b1100011, 3'd0, 1'b0, 1'b0, 0);
    run_instr("bne_t", 7'b1100011, 3'd1, 1'b0, 1'b0, 0);
    run_instr("blt_unsup", 7'b1100011, 3'd4, 1'b0, 1'b1, 0);
    run_instr("illegal", 7'b1111111, 3'd0, 1'b0, 1'b0, 0);
    run_instr("after_ill", 7'b0010011, 3'd7, 1'b0, 1'b0, 0);
    run_instr("lw_stall", 7'b0000011, 3'd2, 1'b0, 1'b0, 3);

    // Abandon a load partway through.
    opcode = 7'b0000011;
    cycle("mid", 0, 1'b1);
    cycle("mid", 1, 1'b0);
    cycle("mid", 2, 1'b1);
    reset_cycle();
    run_instr("post_mid", 7'b0110011, 3'd6, 1'b0, 1'b0, 1);

    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 3)];
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr("rand", op, 3'($urandom), 1'($urandom),
                1'($urandom), 3);
    end

    // Both instances in FETCH; only the bounded one may give up.
    rst = 1'b0; rst_to = 1'b0;
    @(negedge clk);
    chk("reset2", obs, 21'd0);
    chk("reset2_to", obs_to, 21'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; rst_to = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit rdy;
      rdy = (i == 5);
      mem_ready = rdy;
      @(negedge clk);
      chk("wait_forever", obs,
          exp_vec(0, rdy, 1'b0, opcode, funct3, funct7b5, zero));
      chk("timeout", obs_to,
          exp_vec(0, rdy, i == 2, opcode, funct3, funct7b5, zero));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("to_decode", obs_to,
        exp_vec(1, mem_ready, 1'b0, opcode, funct3, funct7b5, zero));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
